// File: rtl/csr_regfile_pkg.sv
// rtl/csr_regfile_pkg.sv - shared types, CSR addresses and trap cause codes for the CSR file
package csr_regfile_pkg;

    typedef enum logic [2:0] {
        CSR_NONE = 3'd0,
        CSR_RW   = 3'd1,
        CSR_RS   = 3'd2,
        CSR_RC   = 3'd3,
        CSR_RWI  = 3'd5,
        CSR_RSI  = 3'd6,
        CSR_RCI  = 3'd7
    } csr_op_t;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_M = 2'b11
    } priv_t;

    localparam logic [11:0] CSR_SATP      = 12'h180;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_U    = 32'd8;
    localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
    localparam logic [31:0] IRQ_MTIMER       = 32'd7;
    localparam logic [31:0] CAUSE_IRQ_MTIMER = 32'h8000_0000 | IRQ_MTIMER;

    // Set/clear forms with a zero operand are pure reads and must not count as writes.
    function automatic logic csr_op_writes(input csr_op_t op, input logic [31:0] wd);
        case (op)
            CSR_RW, CSR_RWI:                   return 1'b1;
            CSR_RS, CSR_RSI, CSR_RC, CSR_RCI: return (wd != 32'h0);
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] csr_apply_op(input csr_op_t op, input logic [31:0] old,
                                                 input logic [31:0] wd);
        case (op)
            CSR_RW, CSR_RWI: return wd;
            CSR_RS, CSR_RSI: return old | wd;
            CSR_RC, CSR_RCI: return old & ~wd;
            default:         return old;
        endcase
    endfunction

endpackage

// File: rtl/csr_regfile_counter64.sv
// rtl/csr_regfile_counter64.sv - 64-bit wrapping counter with independently writable halves
module csr_counter64 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic [63:0] sum;

    // A write to either half suppresses the increment for that cycle.
    always_comb begin
        sum  = {hi_q, lo_q} + 64'd1;
        lo_d = lo_q;
        hi_d = hi_q;
        if (wr_lo || wr_hi) begin
            if (wr_lo) lo_d = wdata;
            if (wr_hi) hi_d = wdata;
        end else if (inc) begin
            lo_d = sum[31:0];
            hi_d = sum[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lo_q <= 32'h0;
            hi_q <= 32'h0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign value = {hi_q, lo_q};

endmodule

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - machine-mode CSR file and trap controller beside the EX stage
import csr_regfile_pkg::*;

module csr_regfile #(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RESET = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_instr_i,
    input  logic [11:0] csr_addr_i,
    input  csr_op_t     csr_op_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_illegal_o,
    input  logic        ex_ecall_i,
    input  logic        ex_ebreak_i,
    input  logic        ex_mret_i,
    input  logic        ex_illegal_i,
    input  logic        instr_retire_i,
    input  logic        timer_irq_i,
    output logic        trap_redirect_o,
    output logic [31:0] trap_pc_o,
    output logic [1:0]  priv_mode_o,
    output logic [31:0] satp_o
);

    priv_t       priv_q, priv_d;
    priv_t       mstatus_mpp_q, mstatus_mpp_d;
    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_mtie_q, mie_mtie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [31:0] satp_q, satp_d;

    logic [63:0] mcycle, minstret;
    logic [31:0] mstatus_rd;
    logic [31:0] rdata;
    logic        csr_impl;
    logic        csr_wr_req;
    logic        csr_illegal;
    logic        csr_we;
    logic [31:0] wval;
    logic        irq_take;
    logic        trap_take;
    logic        mret_take;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;

    assign mstatus_rd = {19'b0, mstatus_mpp_q, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

    always_comb begin
        rdata    = 32'h0;
        csr_impl = 1'b1;
        case (csr_addr_i)
            CSR_MSTATUS:   rdata = mstatus_rd;
            CSR_MISA:      rdata = MISA_VALUE;
            CSR_MIE:       rdata = {24'b0, mie_mtie_q, 7'b0};
            CSR_MIP:       rdata = {24'b0, timer_irq_i, 7'b0};
            CSR_MTVEC:     rdata = mtvec_q;
            CSR_MSCRATCH:  rdata = mscratch_q;
            CSR_MEPC:      rdata = mepc_q;
            CSR_MCAUSE:    rdata = mcause_q;
            CSR_MTVAL:     rdata = mtval_q;
            CSR_SATP:      rdata = satp_q;
            CSR_MCYCLE:    rdata = mcycle[31:0];
            CSR_MCYCLEH:   rdata = mcycle[63:32];
            CSR_MINSTRET:  rdata = minstret[31:0];
            CSR_MINSTRETH: rdata = minstret[63:32];
            CSR_MHARTID:   rdata = HART_ID;
            default:       csr_impl = 1'b0;
        endcase
    end

    assign csr_wr_req  = csr_op_writes(csr_op_i, csr_wdata_i);
    assign csr_illegal = (csr_op_i != CSR_NONE) &&
                         (!csr_impl || (csr_addr_i[9:8] > priv_q) ||
                          (csr_wr_req && (csr_addr_i[11:10] == 2'b11)));
    assign irq_take    = timer_irq_i && mie_mtie_q && ex_valid_i &&
                         ((priv_q == PRIV_U) || mstatus_mie_q);

    always_comb begin
        trap_take  = 1'b1;
        mret_take  = 1'b0;
        trap_cause = 32'h0;
        trap_tval  = 32'h0;
        if (irq_take) begin
            trap_cause = CAUSE_IRQ_MTIMER;
        end else if (ex_illegal_i || csr_illegal) begin
            trap_cause = CAUSE_ILLEGAL;
            trap_tval  = ex_instr_i;
        end else if (ex_ebreak_i) begin
            trap_cause = CAUSE_BREAKPOINT;
            trap_tval  = ex_pc_i;
        end else if (ex_ecall_i) begin
            trap_cause = (priv_q == PRIV_M) ? CAUSE_ECALL_M : CAUSE_ECALL_U;
        end else if (ex_mret_i && (priv_q == PRIV_U)) begin
            trap_cause = CAUSE_ILLEGAL;
            trap_tval  = ex_instr_i;
        end else begin
            trap_take = 1'b0;
            mret_take = ex_mret_i;
        end
    end

    assign csr_we = csr_wr_req && !trap_take;
    assign wval   = csr_apply_op(csr_op_i, rdata, csr_wdata_i);

    always_comb begin
        priv_d         = priv_q;
        mstatus_mpp_d  = mstatus_mpp_q;
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        satp_d         = satp_q;
        if (csr_we) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = wval[3];
                    mstatus_mpie_d = wval[7];
                    mstatus_mpp_d  = (wval[12:11] == 2'b11) ? PRIV_M : PRIV_U;
                end
                CSR_MIE:      mie_mtie_d = wval[7];
                CSR_MTVEC:    mtvec_d    = {wval[31:2], 2'b00};
                CSR_MSCRATCH: mscratch_d = wval;
                CSR_MEPC:     mepc_d     = {wval[31:2], 2'b00};
                CSR_MCAUSE:   mcause_d   = wval;
                CSR_MTVAL:    mtval_d    = wval;
                CSR_SATP:     satp_d     = wval;
                default: ;
            endcase
        end
        if (trap_take) begin
            mepc_d         = {ex_pc_i[31:2], 2'b00};
            mcause_d       = trap_cause;
            mtval_d        = trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            mstatus_mpp_d  = priv_q;
            priv_d         = PRIV_M;
        end else if (mret_take) begin
            priv_d         = mstatus_mpp_q;
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
            mstatus_mpp_d  = PRIV_U;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            priv_q         <= PRIV_M;
            mstatus_mpp_q  <= PRIV_U;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= 32'h0;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            mtval_q        <= 32'h0;
            satp_q         <= 32'h0;
        end else begin
            priv_q         <= priv_d;
            mstatus_mpp_q  <= mstatus_mpp_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            satp_q         <= satp_d;
        end
    end

    csr_counter64 u_mcycle (
        .clk    (clk),
        .resetn (rst),
        .inc    (1'b1),
        .wr_lo  (csr_we && (csr_addr_i == CSR_MCYCLE)),
        .wr_hi  (csr_we && (csr_addr_i == CSR_MCYCLEH)),
        .wdata  (wval),
        .value  (mcycle)
    );

    // A trapped instruction never retires, whatever the pipeline claims.
    csr_counter64 u_minstret (
        .clk    (clk),
        .resetn (rst),
        .inc    (instr_retire_i && !trap_take),
        .wr_lo  (csr_we && (csr_addr_i == CSR_MINSTRET)),
        .wr_hi  (csr_we && (csr_addr_i == CSR_MINSTRETH)),
        .wdata  (wval),
        .value  (minstret)
    );

    assign csr_rdata_o     = rdata;
    assign csr_illegal_o   = csr_illegal && rst;
    assign trap_redirect_o = (trap_take || mret_take) && rst;
    assign trap_pc_o       = trap_take ? mtvec_q : mepc_q;
    assign priv_mode_o     = priv_q;
    assign satp_o          = satp_q;

endmodule

// File: tb/tb_csr_regfile.sv
// tb/tb_csr_regfile.sv - vector-table bench with expected-result queue for csr_regfile
module tb_csr_regfile;
    import csr_regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i;
    logic [31:0] ex_pc_i, ex_instr_i, csr_wdata_i;
    logic [11:0] csr_addr_i;
    csr_op_t     csr_op_i;
    logic        ex_ecall_i, ex_ebreak_i, ex_mret_i, ex_illegal_i, instr_retire_i, timer_irq_i;
    logic [31:0] csr_rdata_o, trap_pc_o, satp_o;
    logic        csr_illegal_o, trap_redirect_o;
    logic [1:0]  priv_mode_o;

    csr_regfile #(.HART_ID(32'd5)) dut (
        .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .ex_instr_i(ex_instr_i),
        .csr_addr_i(csr_addr_i), .csr_op_i(csr_op_i), .csr_wdata_i(csr_wdata_i),
        .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o), .ex_ecall_i(ex_ecall_i),
        .ex_ebreak_i(ex_ebreak_i), .ex_mret_i(ex_mret_i), .ex_illegal_i(ex_illegal_i),
        .instr_retire_i(instr_retire_i), .timer_irq_i(timer_irq_i),
        .trap_redirect_o(trap_redirect_o), .trap_pc_o(trap_pc_o), .priv_mode_o(priv_mode_o),
        .satp_o(satp_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        csr_op_t     op;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [5:0]  ev;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [2:0]  fl;
        logic [31:0] erd;
        logic [31:0] etpc;
        logic [1:0]  epr;
    } vec_t;

    // ev = {irq, retire, ecall, ebreak, mret, illegal}; fl = {check rdata, illegal, redirect}
    localparam logic [5:0]  E0 = 6'b000000, RT = 6'b010000, IQ = 6'b100000;
    localparam logic [5:0]  EC = 6'b001000, EB = 6'b000100, MR = 6'b000010, IL = 6'b000001;
    localparam logic [2:0]  F_RD = 3'b100, F_ILL = 3'b010, F_RED = 3'b001;
    localparam logic [1:0]  PM = 2'b11, PU = 2'b00;
    localparam logic [31:0] Z = 32'h0;
    localparam int          N_RST = 10;

    vec_t vt[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t v(input string n, input csr_op_t op, input logic [11:0] a,
                               input logic [31:0] wd, input logic [5:0] ev, input logic [31:0] pc,
                               input logic [31:0] ins, input logic [2:0] fl, input logic [31:0] erd,
                               input logic [31:0] etpc, input logic [1:0] epr);
        vec_t t;
        t.name = n; t.op = op; t.addr = a; t.wd = wd; t.ev = ev; t.pc = pc; t.ins = ins;
        t.fl = fl; t.erd = erd; t.etpc = etpc; t.epr = epr;
        return t;
    endfunction

    task automatic drive_idle();
        ex_valid_i = 1'b0; ex_pc_i = Z; ex_instr_i = Z; csr_addr_i = 12'h0; csr_op_i = CSR_NONE;
        csr_wdata_i = Z; ex_ecall_i = 1'b0; ex_ebreak_i = 1'b0; ex_mret_i = 1'b0;
        ex_illegal_i = 1'b0; instr_retire_i = 1'b0; timer_irq_i = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic compare_front();
        vec_t t;
        logic bad;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: no expected entry, got rdata=%h", csr_rdata_o);
            return;
        end
        t = exp_q.pop_front();
        bad = 1'b0;
        if (t.fl[2] && (csr_rdata_o !== t.erd)) bad = 1'b1;
        if (csr_illegal_o !== t.fl[1]) bad = 1'b1;
        if (trap_redirect_o !== t.fl[0]) bad = 1'b1;
        if (t.fl[0] && (trap_pc_o !== t.etpc)) bad = 1'b1;
        if (priv_mode_o !== t.epr) bad = 1'b1;
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got rdata=%h ill=%b redir=%b tpc=%h priv=%b, expected rdata=%h ill=%b redir=%b tpc=%h priv=%b",
                     t.name, csr_rdata_o, csr_illegal_o, trap_redirect_o, trap_pc_o, priv_mode_o,
                     t.erd, t.fl[1], t.fl[0], t.etpc, t.epr);
        end
    endtask

    task automatic apply(input vec_t t);
        @(posedge clk);
        #1;
        ex_valid_i = 1'b1; csr_op_i = t.op; csr_addr_i = t.addr; csr_wdata_i = t.wd;
        ex_pc_i = t.pc; ex_instr_i = t.ins;
        timer_irq_i = t.ev[5]; instr_retire_i = t.ev[4]; ex_ecall_i = t.ev[3];
        ex_ebreak_i = t.ev[2]; ex_mret_i = t.ev[1]; ex_illegal_i = t.ev[0];
        exp_q.push_back(t);
        @(negedge clk);
        compare_front();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1);
    end

    initial begin
        vt.push_back(v("rst_mstatus",  CSR_RS,  12'h300, Z, E0, Z, Z, F_RD, 32'h0,         Z, PM));
        vt.push_back(v("rst_mtvec",    CSR_RS,  12'h305, Z, E0, Z, Z, F_RD, 32'h8000_0000, Z, PM));
        vt.push_back(v("rst_misa",     CSR_RS,  12'h301, Z, E0, Z, Z, F_RD, 32'h4000_0100, Z, PM));
        vt.push_back(v("rst_mhartid",  CSR_RS,  12'hF14, Z, E0, Z, Z, F_RD, 32'h5,         Z, PM));
        vt.push_back(v("rst_mepc",     CSR_RS,  12'h341, Z, E0, Z, Z, F_RD, 32'h0,         Z, PM));
        vt.push_back(v("rst_mcause",   CSR_RS,  12'h342, Z, E0, Z, Z, F_RD, 32'h0,         Z, PM));
        vt.push_back(v("rst_satp",     CSR_RS,  12'h180, Z, E0, Z, Z, F_RD, 32'h0,         Z, PM));
        vt.push_back(v("rst_mscratch", CSR_RS,  12'h340, Z, E0, Z, Z, F_RD, 32'h0,         Z, PM));
        vt.push_back(v("rst_mie",      CSR_RS,  12'h304, Z, E0, Z, Z, F_RD, 32'h0,         Z, PM));
        vt.push_back(v("rst_mtval",    CSR_RS,  12'h343, Z, E0, Z, Z, F_RD, 32'h0,         Z, PM));
        vt.push_back(v("rw_mscratch",  CSR_RW,  12'h340, 32'hDEAD_BEEF, E0, Z, Z, F_RD, 32'h0, Z, PM));
        vt.push_back(v("rs_mscratch",  CSR_RS,  12'h340, 32'h10, E0, Z, Z, F_RD, 32'hDEAD_BEEF, Z, PM));
        vt.push_back(v("rc_mscratch",  CSR_RC,  12'h340, 32'hF,  E0, Z, Z, F_RD, 32'hDEAD_BEFF, Z, PM));
        vt.push_back(v("rci_zero",     CSR_RCI, 12'h340, Z,      E0, Z, Z, F_RD, 32'hDEAD_BEF0, Z, PM));
        vt.push_back(v("rd_mscratch",  CSR_RS,  12'h340, Z,      E0, Z, Z, F_RD, 32'hDEAD_BEF0, Z, PM));
        vt.push_back(v("unimpl",       CSR_RS,  12'h7C0, Z, E0, 32'h10, 32'h7C00_2573, F_RD|F_ILL|F_RED, 32'h0, 32'h8000_0000, PM));
        vt.push_back(v("cause_unimpl", CSR_RS,  12'h342, Z, E0, Z, Z, F_RD, 32'h2,         Z, PM));
        vt.push_back(v("tval_unimpl",  CSR_RS,  12'h343, Z, E0, Z, Z, F_RD, 32'h7C00_2573, Z, PM));
        vt.push_back(v("wr_readonly",  CSR_RW,  12'hF14, 32'h1, E0, 32'h14, 32'hF140_9073, F_RD|F_ILL|F_RED, 32'h5, 32'h8000_0000, PM));
        vt.push_back(v("rsi_ro_zero",  CSR_RSI, 12'hF14, Z, E0, Z, Z, F_RD, 32'h5,         Z, PM));
        vt.push_back(v("wr_mtvec",     CSR_RW,  12'h305, 32'h103, E0, Z, Z, F_RD, 32'h8000_0000, Z, PM));
        vt.push_back(v("rd_mtvec",     CSR_RS,  12'h305, Z, E0, Z, Z, F_RD, 32'h100,       Z, PM));
        vt.push_back(v("set_mie",      CSR_RSI, 12'h300, 32'h8, E0, Z, Z, F_RD, 32'h1800,  Z, PM));
        vt.push_back(v("ecall_m",      CSR_NONE,12'h300, Z, EC, 32'h40, Z, F_RD|F_RED, 32'h1808, 32'h100, PM));
        vt.push_back(v("mepc_ecall",   CSR_RS,  12'h341, Z, E0, Z, Z, F_RD, 32'h40,        Z, PM));
        vt.push_back(v("mcause_ecall", CSR_RS,  12'h342, Z, E0, Z, Z, F_RD, 32'd11,        Z, PM));
        vt.push_back(v("mstatus_ecall",CSR_RS,  12'h300, Z, E0, Z, Z, F_RD, 32'h1880,      Z, PM));
        vt.push_back(v("clr_mpp",      CSR_RC,  12'h300, 32'h1800, E0, Z, Z, F_RD, 32'h1880, Z, PM));
        vt.push_back(v("wr_mepc",      CSR_RW,  12'h341, 32'h202, E0, Z, Z, F_RD, 32'h40,  Z, PM));
        vt.push_back(v("mret_to_u",    CSR_NONE,12'h341, Z, MR, Z, Z, F_RD|F_RED, 32'h200, 32'h200, PM));
        vt.push_back(v("u_rd_mstatus", CSR_RS,  12'h300, Z, E0, 32'h204, 32'h3000_2573, F_RD|F_ILL|F_RED, 32'h88, 32'h100, PU));
        vt.push_back(v("cause_u_rd",   CSR_RS,  12'h342, Z, E0, Z, Z, F_RD, 32'h2,         Z, PM));
        vt.push_back(v("tval_u_rd",    CSR_RS,  12'h343, Z, E0, Z, Z, F_RD, 32'h3000_2573, Z, PM));
        vt.push_back(v("mepc_u_rd",    CSR_RS,  12'h341, Z, E0, Z, Z, F_RD, 32'h204,       Z, PM));
        vt.push_back(v("mret_again",   CSR_NONE,12'h300, Z, MR, Z, Z, F_RD|F_RED, 32'h80,  32'h204, PM));
        vt.push_back(v("ecall_u",      CSR_NONE,12'h300, Z, EC, 32'h300, Z, F_RD|F_RED, 32'h88, 32'h100, PU));
        vt.push_back(v("cause_ecall_u",CSR_RS,  12'h342, Z, E0, Z, Z, F_RD, 32'h8,         Z, PM));
        vt.push_back(v("set_mtie",     CSR_RS,  12'h304, 32'h80, E0, Z, Z, F_RD, 32'h0,    Z, PM));
        vt.push_back(v("set_mie2",     CSR_RS,  12'h300, 32'h8,  E0, Z, Z, F_RD, 32'h80,   Z, PM));
        vt.push_back(v("irq_vs_ecall", CSR_NONE,12'h342, Z, IQ|EC|RT, 32'h500, Z, F_RD|F_RED, 32'h8, 32'h100, PM));
        vt.push_back(v("cause_irq",    CSR_RS,  12'h342, Z, IQ, Z, Z, F_RD, 32'h8000_0007, Z, PM));
        vt.push_back(v("mepc_irq",     CSR_RS,  12'h341, Z, IQ, Z, Z, F_RD, 32'h500,       Z, PM));
        vt.push_back(v("ebreak",       CSR_NONE,12'h342, Z, EB, 32'h600, Z, F_RD|F_RED, 32'h8000_0007, 32'h100, PM));
        vt.push_back(v("tval_ebreak",  CSR_RS,  12'h343, Z, E0, Z, Z, F_RD, 32'h600,       Z, PM));
        vt.push_back(v("cause_ebreak", CSR_RS,  12'h342, Z, E0, Z, Z, F_RD, 32'h3,         Z, PM));
        vt.push_back(v("ill_over_bp",  CSR_NONE,12'h340, Z, IL|EB, 32'h700, 32'hFFFF_FFFF, F_RD|F_RED, 32'hDEAD_BEF0, 32'h100, PM));
        vt.push_back(v("tval_ill",     CSR_RS,  12'h343, Z, E0, Z, Z, F_RD, 32'hFFFF_FFFF, Z, PM));
        vt.push_back(v("cause_ill",    CSR_RS,  12'h342, Z, E0, Z, Z, F_RD, 32'h2,         Z, PM));
        vt.push_back(v("wr_satp",      CSR_RW,  12'h180, 32'h8000_1234, E0, Z, Z, F_RD, 32'h0, Z, PM));
        vt.push_back(v("rd_satp",      CSR_RS,  12'h180, Z, E0, Z, Z, F_RD, 32'h8000_1234, Z, PM));
        vt.push_back(v("wr_mie_all",   CSR_RW,  12'h304, 32'hFFFF_FFFF, E0, Z, Z, F_RD, 32'h80, Z, PM));
        vt.push_back(v("rd_mie_mask",  CSR_RS,  12'h304, Z, E0, Z, Z, F_RD, 32'h80,        Z, PM));
        vt.push_back(v("rd_mip_hi",    CSR_RS,  12'h344, Z, IQ, Z, Z, F_RD, 32'h80,        Z, PM));
        vt.push_back(v("rd_mip_lo",    CSR_RS,  12'h344, Z, E0, Z, Z, F_RD, 32'h0,         Z, PM));
        vt.push_back(v("wr_mcycleh",   CSR_RW,  12'hB80, 32'h12, E0, Z, Z, F_RD, 32'h0,    Z, PM));
        vt.push_back(v("wr_mcycle",    CSR_RW,  12'hB00, 32'hFFFF_FFFF, E0, Z, Z, 3'b000, Z, Z, PM));
        vt.push_back(v("mcycle_max",   CSR_RS,  12'hB00, Z, E0, Z, Z, F_RD, 32'hFFFF_FFFF, Z, PM));
        vt.push_back(v("mcycle_wrap",  CSR_RS,  12'hB00, Z, E0, Z, Z, F_RD, 32'h0,         Z, PM));
        vt.push_back(v("mcycleh_carry",CSR_RS,  12'hB80, Z, E0, Z, Z, F_RD, 32'h13,        Z, PM));
        vt.push_back(v("wr_mcycle5",   CSR_RW,  12'hB00, 32'h5, E0, Z, Z, F_RD, 32'h2,     Z, PM));
        vt.push_back(v("rd_mcycle5",   CSR_RS,  12'hB00, Z, E0, Z, Z, F_RD, 32'h5,         Z, PM));
        vt.push_back(v("wr_minstret",  CSR_RW,  12'hB02, 32'hFFFF_FFFF, RT, Z, Z, F_RD, 32'h0, Z, PM));
        vt.push_back(v("minstret_max", CSR_RS,  12'hB02, Z, RT, Z, Z, F_RD, 32'hFFFF_FFFF, Z, PM));
        vt.push_back(v("minstreth_cy", CSR_RS,  12'hB82, Z, E0, Z, Z, F_RD, 32'h1,         Z, PM));
        vt.push_back(v("minstret_wrap",CSR_RS,  12'hB02, Z, E0, Z, Z, F_RD, 32'h0,         Z, PM));
        vt.push_back(v("clr_mpp2",     CSR_RC,  12'h300, 32'h1800, E0, Z, Z, F_RD, 32'h1800, Z, PM));
        vt.push_back(v("mret_to_u2",   CSR_NONE,12'h341, Z, MR, Z, Z, F_RD|F_RED, 32'h700, 32'h700, PM));
        vt.push_back(v("mret_in_u",    CSR_NONE,12'h000, Z, MR, 32'h704, 32'h3020_0073, F_RD|F_RED, 32'h0, 32'h100, PU));
        vt.push_back(v("cause_mret_u", CSR_RS,  12'h342, Z, E0, Z, Z, F_RD, 32'h2,         Z, PM));
        vt.push_back(v("tval_mret_u",  CSR_RS,  12'h343, Z, E0, Z, Z, F_RD, 32'h3020_0073, Z, PM));

        drive_idle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_redirect", {31'b0, trap_redirect_o}, 32'h0);
        check("rst_illegal",  {31'b0, csr_illegal_o},   32'h0);
        @(negedge clk);
        check("rst_priv",     {30'b0, priv_mode_o},     32'h3);
        check("rst_satp_o",   satp_o,                   32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < vt.size(); i++) apply(vt[i]);

        @(posedge clk);
        #1 drive_idle();
        @(negedge clk);
        check("satp_o_set", satp_o, 32'h8000_1234);

        @(posedge clk);
        #1;
        rst = 1'b0; ex_valid_i = 1'b1; ex_ecall_i = 1'b1; ex_pc_i = 32'h800;
        @(negedge clk);
        check("rst_mid_ecall_redir", {31'b0, trap_redirect_o}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        check("post_rst_redir", {31'b0, trap_redirect_o}, 32'h0);
        check("post_rst_satp",  satp_o, 32'h0);
        for (int i = 0; i < N_RST; i++) apply(vt[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
